// File: rtl/spiker_pkg.sv
// Shared constants, word-count helper and FSM state type for the spike AER encoder.
package spiker_pkg;

    localparam int SPIKER_WIDTH    = 32;
    localparam int SPIKER_N_SPIKES = 784;

    function automatic int word_count(input int n_spikes, input int width);
        return (n_spikes + width - 1) / width;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } aer_state_e;

endpackage

// File: rtl/spiker_aer_encoder_if.sv
// Address-event handshake between the encoder and the SNN core input queue.
interface spiker_aer_encoder_if
    import spiker_pkg::*;
#(
    parameter int ADDR_W = $clog2(SPIKER_N_SPIKES)
);

    logic              aer_valid_o;
    logic              aer_ready_i;
    logic [ADDR_W-1:0] aer_addr_o;

    modport master (
        output aer_valid_o,
        output aer_addr_o,
        input  aer_ready_i
    );

    modport slave (
        input  aer_valid_o,
        input  aer_addr_o,
        output aer_ready_i
    );

endinterface

// File: rtl/spiker_lsb_encoder.sv
// Finds the lowest set bit of a word: presence flag, its index and a one-hot mask of it.
module spiker_lsb_encoder #(
    parameter int WIDTH = 32,
    parameter int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] word,
    output logic             found,
    output logic [BIT_W-1:0] idx,
    output logic [WIDTH-1:0] mask
);

    assign found = |word;
    // Two's-complement trick isolates the lowest set bit.
    assign mask  = word & (~word + WIDTH'(1));

    // NOTE: combinational blocks assign a default first so no path leaves idx unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (word[i]) idx = BIT_W'(i);
        end
    end

endmodule

// File: rtl/spiker_aer_encoder.sv
// Serialises a snapshot of the spike vector into ascending-address AER events over valid/ready.
module spiker_aer_encoder
    import spiker_pkg::*;
#(
    parameter int WIDTH    = SPIKER_WIDTH,
    parameter int N_SPIKES = SPIKER_N_SPIKES
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [N_SPIKES-1:0]            spikes_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [$clog2(N_SPIKES+1)-1:0]  spike_cnt_o,
    spiker_aer_encoder_if.master           aer
);

    localparam int DATA_WIDTH = word_count(N_SPIKES, WIDTH);
    localparam int ADDR_W     = $clog2(N_SPIKES);
    localparam int CNT_W      = $clog2(N_SPIKES + 1);
    localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int BIT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PAD_W      = DATA_WIDTH * WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    aer_state_e                       state_q, state_d;
    logic [DATA_WIDTH-1:0][WIDTH-1:0] snap_q;
    logic [PAD_W-1:0]                 padded;
    logic [IDX_W-1:0]                 idx_q, idx_d, idx_next;
    logic [WIDTH-1:0]                 word_q, word_d, mask;
    logic [BIT_W-1:0]                 lsb;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             found;
    logic                             snap_load;
    logic                             handshake;

    spiker_lsb_encoder #(
        .WIDTH (WIDTH),
        .BIT_W (BIT_W)
    ) u_lsb (
        .word  (word_q),
        .found (found),
        .idx   (lsb),
        .mask  (mask)
    );

    // Padding bits above N_SPIKES never produce events.
    always_comb begin
        padded                 = '0;
        padded[N_SPIKES-1:0]   = spikes_i;
    end

    assign idx_next  = idx_q + IDX_W'(1);
    assign busy_o    = (state_q == SCAN);
    assign done_o    = (state_q == DONE);

    // Valid is a function of registered state only, never of aer_ready_i.
    assign aer.aer_valid_o = busy_o && found;
    assign aer.aer_addr_o  = aer.aer_valid_o
                           ? ADDR_W'(idx_q) * ADDR_W'(WIDTH) + ADDR_W'(lsb)
                           : '0;
    assign handshake       = aer.aer_valid_o && aer.aer_ready_i;
    assign spike_cnt_o     = cnt_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        snap_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    snap_load = 1'b1;
                    idx_d     = '0;
                    word_d    = padded[WIDTH-1:0];
                    cnt_d     = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (handshake) begin
                    word_d = word_q & ~mask;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
                // Empty word, or the bit just accepted was its last one: move on this cycle.
                if (!found || (handshake && (word_q & ~mask) == '0)) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_next;
                        word_d = snap_q[idx_next];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the snapshot is reset along with the control state so no stale spikes survive a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            if (snap_load) snap_q <= padded;
        end
    end

endmodule
